// File: rtl/ooo_pkg.sv
// Shared OoO front-end definitions: opcode map, dispatch classes and dispatch FSM states.
// Register-register ALU forms occupy 0x01-0x08; immediate forms 0x09-0x0F.
package ooo_pkg;

    localparam int unsigned INST_W  = 32;
    localparam int unsigned OPC_W   = 6;

    typedef logic [OPC_W-1:0] opcode_t;

    localparam opcode_t OP_NOP    = 6'h00;
    localparam opcode_t OP_ADD    = 6'h01;
    localparam opcode_t OP_SUB    = 6'h02;
    localparam opcode_t OP_SLL    = 6'h03;
    localparam opcode_t OP_SRA    = 6'h04;
    localparam opcode_t OP_SRL    = 6'h05;
    localparam opcode_t OP_AND    = 6'h06;
    localparam opcode_t OP_OR     = 6'h07;
    localparam opcode_t OP_XOR    = 6'h08;
    localparam opcode_t OP_ADDI   = 6'h09;
    localparam opcode_t OP_SUBI   = 6'h0A;
    localparam opcode_t OP_SLLI   = 6'h0B;
    localparam opcode_t OP_SRAI   = 6'h0C;
    localparam opcode_t OP_SRLI   = 6'h0D;
    localparam opcode_t OP_ANDI   = 6'h0E;
    localparam opcode_t OP_XORI   = 6'h0F;
    localparam opcode_t OP_LW     = 6'h11;
    localparam opcode_t OP_SW     = 6'h12;
    localparam opcode_t OP_BR     = 6'h13;
    localparam opcode_t OP_BEQ    = 6'h14;
    localparam opcode_t OP_BNE    = 6'h15;
    localparam opcode_t OP_BLT    = 6'h16;
    localparam opcode_t OP_BGE    = 6'h17;
    localparam opcode_t OP_BLTU   = 6'h18;
    localparam opcode_t OP_BGEU   = 6'h19;
    localparam opcode_t OP_J      = 6'h1A;
    localparam opcode_t OP_JAL    = 6'h1B;
    localparam opcode_t OP_JALR   = 6'h1C;
    localparam opcode_t OP_RET    = 6'h1D;
    localparam opcode_t OP_STRCNT = 6'h20;
    localparam opcode_t OP_STPCNT = 6'h21;
    localparam opcode_t OP_LDCC   = 6'h22;
    localparam opcode_t OP_LDIC   = 6'h23;
    localparam opcode_t OP_TX     = 6'h30;
    localparam opcode_t OP_HALT   = 6'h31;

    typedef enum logic [1:0] {CLS_ALU, CLS_LSQ, CLS_BR, CLS_DROP} cls_e;

    typedef enum logic {ST_RUN, ST_HALTED} state_e;

    function automatic opcode_t opcode_of(input logic [INST_W-1:0] inst);
        return inst[INST_W-1 -: OPC_W];
    endfunction

endpackage

// File: rtl/dispatch_ctrl_if.sv
// Decode -> dispatch -> issue-queue handshake bundle for dispatch_ctrl.
// slave: the dispatch controller; master: the surrounding pipeline (decode, queues, ROB).
interface dispatch_ctrl_if #(
    parameter int unsigned TAG_W = 4
);
    logic              inst_valid;
    logic [31:0]       inst;
    logic              inst_ready;
    logic              alu_rs_full;
    logic              lsq_full;
    logic              br_rs_full;
    logic              alu_disp;
    logic              lsq_disp;
    logic              br_disp;
    logic [31:0]       disp_inst;
    logic [TAG_W-1:0]  disp_tag;
    logic              disp_wr_rd;
    logic              disp_reg_dest;
    logic              disp_mem_wen;
    logic              commit_valid;
    logic              flush;
    logic              halted;
    logic [TAG_W:0]    rob_count;

    modport slave (
        input  inst_valid, inst, alu_rs_full, lsq_full, br_rs_full, commit_valid, flush,
        output inst_ready, alu_disp, lsq_disp, br_disp, disp_inst, disp_tag,
               disp_wr_rd, disp_reg_dest, disp_mem_wen, halted, rob_count
    );

    modport master (
        output inst_valid, inst, alu_rs_full, lsq_full, br_rs_full, commit_valid, flush,
        input  inst_ready, alu_disp, lsq_disp, br_disp, disp_inst, disp_tag,
               disp_wr_rd, disp_reg_dest, disp_mem_wen, halted, rob_count
    );
endinterface

// File: rtl/dispatch_classify.sv
// Combinational opcode decoder: dispatch class plus destination/store flags and HALT detect.
module dispatch_classify
    import ooo_pkg::*;
(
    input  opcode_t opcode,
    output cls_e    cls_c,
    output logic    wr_rd_c,
    output logic    reg_dest_c,
    output logic    mem_wen_c,
    output logic    is_halt_c
);

    always_comb begin
        cls_c      = CLS_DROP;
        wr_rd_c    = 1'b0;
        reg_dest_c = 1'b0;
        mem_wen_c  = 1'b0;
        is_halt_c  = 1'b0;
        case (opcode) inside
            [OP_ADD:OP_XOR]: begin
                cls_c      = CLS_ALU;
                wr_rd_c    = 1'b1;
                reg_dest_c = 1'b1;
            end
            [OP_ADDI:OP_XORI], OP_LDCC, OP_LDIC: begin
                cls_c      = CLS_ALU;
                reg_dest_c = 1'b1;
            end
            // Counter start/stop run on the ALU but write no register
            OP_STRCNT, OP_STPCNT: cls_c = CLS_ALU;
            OP_LW: begin
                cls_c      = CLS_LSQ;
                reg_dest_c = 1'b1;
            end
            OP_SW: begin
                cls_c     = CLS_LSQ;
                mem_wen_c = 1'b1;
            end
            OP_JAL, OP_JALR: begin
                cls_c      = CLS_BR;
                reg_dest_c = 1'b1;
            end
            [OP_BR:OP_J], OP_RET: cls_c = CLS_BR;
            OP_HALT: begin
                cls_c     = CLS_BR;
                is_halt_c = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dispatch_ctrl.sv
// Single-entry dispatch buffer between decode and the issue queues with ROB tag allocation.
// Optional DISPATCH_PERF_CNT_EN adds a saturating stall_cycles counter port.
module dispatch_ctrl
    import ooo_pkg::*;
#(
    parameter int unsigned ROB_DEPTH = 16,
    parameter int unsigned TAG_W     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    dispatch_ctrl_if.slave    bus
`ifdef DISPATCH_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cycles
`endif
);

    localparam int unsigned CNT_W = TAG_W + 1;

    state_e             state_q, state_d;
    logic               buf_valid_q, buf_valid_d;
    logic [INST_W-1:0]  buf_inst_q, buf_inst_d;
    logic [TAG_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   rob_count_q, rob_count_d;

    cls_e               cls;
    logic               wr_rd, reg_dest, mem_wen, is_halt;
    logic               tgt_full, rob_room, disp_ok, leaving, ready, commit_ok;

    dispatch_classify u_classify (
        .opcode     (opcode_of(buf_inst_q)),
        .cls_c      (cls),
        .wr_rd_c    (wr_rd),
        .reg_dest_c (reg_dest),
        .mem_wen_c  (mem_wen),
        .is_halt_c  (is_halt)
    );

    // Dispatch/accept decision for the current buffer entry
    always_comb begin
        tgt_full = 1'b1;
        unique case (cls)
            CLS_ALU: tgt_full = bus.alu_rs_full;
            CLS_LSQ: tgt_full = bus.lsq_full;
            CLS_BR:  tgt_full = bus.br_rs_full;
            default: tgt_full = 1'b1;
        endcase
        rob_room  = rob_count_q < CNT_W'(ROB_DEPTH);
        disp_ok   = buf_valid_q && (cls != CLS_DROP) && !tgt_full && rob_room && !bus.flush;
        leaving   = buf_valid_q && ((cls == CLS_DROP) || disp_ok);
        // Nothing is accepted behind a HALT that is leaving this cycle
        ready     = (state_q == ST_RUN) && (!buf_valid_q || leaving) && !bus.flush
                    && !(disp_ok && is_halt);
        commit_ok = bus.commit_valid && (rob_count_q != '0);
    end

    // Next-state: flush dominates dispatch, accept and commit
    always_comb begin
        state_d     = state_q;
        buf_valid_d = buf_valid_q;
        buf_inst_d  = buf_inst_q;
        tail_d      = tail_q;
        rob_count_d = rob_count_q;
        if (bus.flush) begin
            state_d     = ST_RUN;
            buf_valid_d = 1'b0;
            rob_count_d = '0;
        end else begin
            if (disp_ok) begin
                tail_d = tail_q + TAG_W'(1);
                if (is_halt) begin
                    state_d = ST_HALTED;
                end
            end
            if (leaving) begin
                buf_valid_d = 1'b0;
            end
            if (bus.inst_valid && ready) begin
                buf_valid_d = 1'b1;
                buf_inst_d  = bus.inst;
            end
            unique case ({disp_ok, commit_ok})
                2'b10:   rob_count_d = rob_count_q + CNT_W'(1);
                2'b01:   rob_count_d = rob_count_q - CNT_W'(1);
                default: rob_count_d = rob_count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            buf_valid_q <= 1'b0;
            buf_inst_q  <= '0;
            tail_q      <= '0;
            rob_count_q <= '0;
        end else begin
            state_q     <= state_d;
            buf_valid_q <= buf_valid_d;
            buf_inst_q  <= buf_inst_d;
            tail_q      <= tail_d;
            rob_count_q <= rob_count_d;
        end
    end

    assign bus.inst_ready    = ready;
    assign bus.alu_disp      = disp_ok && (cls == CLS_ALU);
    assign bus.lsq_disp      = disp_ok && (cls == CLS_LSQ);
    assign bus.br_disp       = disp_ok && (cls == CLS_BR);
    assign bus.disp_inst     = buf_inst_q;
    assign bus.disp_tag      = tail_q;
    assign bus.disp_wr_rd    = wr_rd;
    assign bus.disp_reg_dest = reg_dest;
    assign bus.disp_mem_wen  = mem_wen;
    assign bus.halted        = (state_q == ST_HALTED);
    assign bus.rob_count     = rob_count_q;

`ifdef DISPATCH_PERF_CNT_EN
    logic stall_now;
    assign stall_now = buf_valid_q && (cls != CLS_DROP) && !disp_ok;

    // Saturating count of cycles a real instruction sat in the buffer undispatched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (stall_now && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Self-checking bench for dispatch_ctrl: directed scenarios plus randomized traffic vs a queue model.
module tb_dispatch_ctrl;

    localparam int DEPTH = 16;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    dispatch_ctrl_if #(.TAG_W(4)) bus ();

`ifdef DISPATCH_PERF_CNT_EN
    logic [31:0] stall_cycles;
`endif

    dispatch_ctrl #(.ROB_DEPTH(16), .TAG_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef DISPATCH_PERF_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference rules written directly from the opcode table
    function automatic int cls_of(input int op);
        if ((op >= 1 && op <= 15) || (op >= 32 && op <= 35)) return 0;
        if (op == 17 || op == 18) return 1;
        if ((op >= 19 && op <= 29) || op == 49) return 2;
        return 3;
    endfunction

    function automatic logic [31:0] mk(input logic [5:0] op);
        logic [25:0] rest;
        rest = 26'($urandom);
        return {op, rest};
    endfunction

    // Model state: buffer as a queue, tag pointer, occupancy, halt flag
    logic [31:0] m_buf[$];
    int          m_tail;
    int          m_cnt;
    bit          m_halt;
    logic [31:0] m_stall;

    always @(negedge clk) begin : model
        int          op, c;
        bit          disp, leave, blocked, exp_rdy;
        logic [31:0] b;
        if (!rst_n) begin
            m_buf.delete();
            m_tail = 0; m_cnt = 0; m_halt = 0; m_stall = '0;
        end
        disp = 0; leave = 0; op = 0; c = 3; b = '0;
        if (m_buf.size() != 0) begin
            b = m_buf[0];
            op = int'(b[31:26]);
            c = cls_of(op);
            blocked = (c == 0 && bus.alu_rs_full) || (c == 1 && bus.lsq_full)
                   || (c == 2 && bus.br_rs_full);
            disp  = (c != 3) && !blocked && (m_cnt < DEPTH) && !bus.flush;
            leave = (c == 3) || disp;
        end
        exp_rdy = !m_halt && (m_buf.size() == 0 || leave) && !bus.flush && !(disp && op == 49);

        check("m_alu_disp", bus.alu_disp, disp && c == 0);
        check("m_lsq_disp", bus.lsq_disp, disp && c == 1);
        check("m_br_disp",  bus.br_disp,  disp && c == 2);
        check("m_ready",    bus.inst_ready, exp_rdy);
        check("m_halted",   bus.halted, m_halt);
        check("m_rob_count", bus.rob_count, m_cnt);
`ifdef DISPATCH_PERF_CNT_EN
        check("m_stall_cycles", stall_cycles, m_stall);
`endif
        if (m_buf.size() != 0) begin
            check("m_disp_inst", bus.disp_inst, b);
            check("m_disp_tag",  bus.disp_tag, m_tail);
            check("m_wr_rd",     bus.disp_wr_rd, op >= 1 && op <= 8);
            check("m_reg_dest",  bus.disp_reg_dest,
                  (c == 0 && op != 32 && op != 33) || op == 17 || op == 27 || op == 28);
            check("m_mem_wen",   bus.disp_mem_wen, op == 18);
        end

        if (rst_n) begin
            if (m_buf.size() != 0 && c != 3 && !disp && m_stall != 32'hFFFF_FFFF) m_stall++;
            if (bus.flush) begin
                m_buf.delete();
                m_cnt = 0;
                m_halt = 0;
            end else begin
                int c0;
                c0 = m_cnt;
                if (disp) begin
                    m_tail = (m_tail + 1) % DEPTH;
                    if (op == 49) m_halt = 1;
                end
                m_cnt = c0 + (disp ? 1 : 0) - ((bus.commit_valid && c0 > 0) ? 1 : 0);
                if (leave) void'(m_buf.pop_front());
                if (bus.inst_valid && exp_rdy) m_buf.push_back(bus.inst);
            end
        end
    end

    task automatic step(input logic v, input logic [31:0] i, input logic af, input logic lf,
                        input logic bf, input logic cv, input logic fl);
        @(posedge clk);
        #1;
        bus.inst_valid   = v;
        bus.inst         = i;
        bus.alu_rs_full  = af;
        bus.lsq_full     = lf;
        bus.br_rs_full   = bf;
        bus.commit_valid = cv;
        bus.flush        = fl;
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        idle();
        idle();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        bus.inst_valid = 1'b0; bus.inst = '0; bus.alu_rs_full = 1'b0; bus.lsq_full = 1'b0;
        bus.br_rs_full = 1'b0; bus.commit_valid = 1'b0; bus.flush = 1'b0;

        @(negedge clk);
        check("rst_ready", bus.inst_ready, 1);
        check("rst_rob", bus.rob_count, 0);
        check("rst_halted", bus.halted, 0);
        check("rst_pulses", {bus.alu_disp, bus.lsq_disp, bus.br_disp}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);

        // ADD, LW, BEQ back to back
        step(1'b1, mk(6'h01), 0, 0, 0, 0, 0);
        check("t1_ready", bus.inst_ready, 1);
        step(1'b1, mk(6'h11), 0, 0, 0, 0, 0);
        check("t1_alu", bus.alu_disp, 1);
        check("t1_tag0", bus.disp_tag, 0);
        check("t1_wr_rd_add", bus.disp_wr_rd, 1);
        step(1'b1, mk(6'h14), 0, 0, 0, 0, 0);
        check("t1_lsq", bus.lsq_disp, 1);
        check("t1_tag1", bus.disp_tag, 1);
        check("t1_wr_rd_lw", bus.disp_wr_rd, 0);
        check("t1_reg_dest_lw", bus.disp_reg_dest, 1);
        idle();
        check("t1_br", bus.br_disp, 1);
        check("t1_tag2", bus.disp_tag, 2);
        idle();
        check("t1_rob3", bus.rob_count, 3);

        // SW held by a full LSQ for 4 cycles
        step(1'b1, mk(6'h12), 0, 1, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 32'h0, 0, 1, 0, 0, 0);
            check("t2_ready_stall", bus.inst_ready, 0);
            check("t2_no_lsq", bus.lsq_disp, 0);
        end
        idle();
        check("t2_lsq", bus.lsq_disp, 1);
        check("t2_mem_wen", bus.disp_mem_wen, 1);
`ifdef DISPATCH_PERF_CNT_EN
        check("t2_stall4", stall_cycles, 4);
`endif

        // Fill the ROB, then wrap the tag after one commit
        do_reset();
        for (int k = 0; k < 17; k++) step(1'b1, mk(6'h09), 0, 0, 0, 0, 0);
        idle();
        check("t3_rob16", bus.rob_count, 16);
        check("t3_hold", bus.alu_disp, 0);
        check("t3_ready0", bus.inst_ready, 0);
        step(1'b0, 32'h0, 0, 0, 0, 1, 0);
        check("t3_hold_commit", bus.alu_disp, 0);
        idle();
        check("t3_wrap_disp", bus.alu_disp, 1);
        check("t3_wrap_tag", bus.disp_tag, 0);
        check("t3_rob15", bus.rob_count, 15);

        // DROP-class stream
        step(1'b1, mk(6'h00), 0, 0, 0, 0, 0);
        step(1'b1, mk(6'h30), 0, 0, 0, 0, 0);
        check("t4_ready_a", bus.inst_ready, 1);
        step(1'b1, mk(6'h3F), 0, 0, 0, 0, 0);
        check("t4_ready_b", bus.inst_ready, 1);
        check("t4_nopulse_b", {bus.alu_disp, bus.lsq_disp, bus.br_disp}, 0);
        idle();
        check("t4_ready_c", bus.inst_ready, 1);
        check("t4_nopulse_c", {bus.alu_disp, bus.lsq_disp, bus.br_disp}, 0);
        check("t4_rob16", bus.rob_count, 16);

        // HALT parks the front end until flush
        step(1'b0, 32'h0, 0, 0, 0, 0, 1);
        step(1'b1, mk(6'h31), 0, 0, 0, 0, 0);
        step(1'b1, mk(6'h01), 0, 0, 0, 0, 0);
        check("t5_br", bus.br_disp, 1);
        check("t5_ready_halt", bus.inst_ready, 0);
        step(1'b1, mk(6'h01), 0, 0, 0, 0, 0);
        check("t5_halted", bus.halted, 1);
        check("t5_ready0", bus.inst_ready, 0);
        check("t5_nopulse", {bus.alu_disp, bus.lsq_disp, bus.br_disp}, 0);
        step(1'b1, mk(6'h01), 0, 0, 0, 0, 1);
        step(1'b1, mk(6'h01), 0, 0, 0, 0, 0);
        check("t5_unhalt", bus.halted, 0);
        check("t5_rob0", bus.rob_count, 0);
        check("t5_ready1", bus.inst_ready, 1);

        // Flush beats dispatch and commit in the same cycle
        idle();
        step(1'b1, mk(6'h02), 0, 0, 0, 0, 0);
        step(1'b0, 32'h0, 0, 0, 0, 1, 1);
        check("t6_flush_nopulse", bus.alu_disp, 0);
        idle();
        check("t6_rob0", bus.rob_count, 0);
        check("t6_empty", bus.alu_disp, 0);

        // Async reset while a store is stalled
        step(1'b1, mk(6'h03), 0, 0, 0, 0, 0);
        step(1'b1, mk(6'h12), 0, 1, 0, 0, 0);
        step(1'b0, 32'h0, 0, 1, 0, 0, 0);
        check("t6_stalled", bus.inst_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        check("t6_arst_ready", bus.inst_ready, 1);
        check("t6_arst_rob", bus.rob_count, 0);
        check("t6_arst_lsq", bus.lsq_disp, 0);
`ifdef DISPATCH_PERF_CNT_EN
        check("t6_arst_stall", stall_cycles, 0);
`endif
        idle();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            logic [5:0] op;
            op = 6'($urandom_range(0, 63));
            step($urandom_range(0, 9) < 7, mk(op),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 4,
                 $urandom_range(0, 39) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dispatch_ctrl.md
Name: dispatch_ctrl

Overview:
- Sits between decode and the issue queues of the OoO pipe. Holds one instruction per cycle in a single-entry dispatch buffer.
- Classifies the opcode as ALU, LSQ, branch, drop or halt, and allocates a reorder-buffer (ROB) tag.
- Dispatches to the correct queue when that queue and the ROB have room. Applies backpressure upstream otherwise.
- Parks the front end after HALT until a flush arrives.

Parameters:
ROB_DEPTH, 16, number of ROB entries; power of two, >= 2
TAG_W, 4, ROB tag width; equals log2(ROB_DEPTH)

Ports:
clk  in  1  pipeline clock
rst_n  in  1  asynchronous active-low reset
inst_valid  in  1  decode has an instruction
inst  in  32  instruction word; opcode = inst[31:26]
inst_ready  out  1  dispatch buffer can accept this cycle
alu_rs_full  in  1  ALU reservation station full
lsq_full  in  1  load/store queue full
br_rs_full  in  1  branch reservation station full
alu_disp  out  1  dispatch pulse to ALU RS
lsq_disp  out  1  dispatch pulse to LSQ
br_disp  out  1  dispatch pulse to branch RS
disp_inst  out  32  instruction being dispatched
disp_tag  out  TAG_W  allocated ROB tag
disp_wr_rd  out  1  Rd write (register-register form)
disp_reg_dest  out  1  instruction writes a destination register
disp_mem_wen  out  1  store
commit_valid  in  1  ROB retires one entry this cycle
flush  in  1  mispredict/exception; squash everything in flight
halted  out  1  HALT dispatched, front end parked
rob_count  out  TAG_W+1  ROB occupancy

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: buffer empty; state RUN; tail=0; rob_count=0; halted=0; all disp_* pulses 0; inst_ready=1.
  - Optional counter: stall_cycles=0.
- Opcode classes:
  - ALU: 0x01–0x0F, 0x20–0x23.
  - LSQ: 0x11 (LW), 0x12 (SW).
  - BR: 0x13–0x1D.
  - HALT: 0x31. HALT goes to the BR queue, i.e. it is dispatched as a branch.
  - DROP: 0x00, 0x30, all other values.
- Decode flags:
  - disp_wr_rd=1 for ADD, SUB, SLL, SRA, SRL, AND, OR, XOR.
  - disp_reg_dest=1 for all ALU class plus LW, JAL (0x1B), JALR (0x1C), LDCC, LDIC; excludes STRCNT (0x20) and STPCNT (0x21).
  - disp_mem_wen=1 for SW only.
- Buffer and acceptance:
  - Accept when inst_valid & inst_ready. The instruction is captured on that clock edge.
  - Dispatch is combinational from the buffer in the following cycle, so minimum latency is 1 cycle.
- Dispatch condition: buffer valid, class not DROP, target queue not full, rob_count < ROB_DEPTH, no flush.
  - Exactly one of alu_disp, lsq_disp, br_disp is high for one cycle.
  - disp_tag = tail. tail increments mod ROB_DEPTH (wraps ROB_DEPTH-1 → 0).
- DROP-class entries leave the buffer silently next cycle. No tag is allocated and no pulse is raised.
- inst_ready = state==RUN & (buffer empty | buffer leaving this cycle) & !flush. This gives full throughput of one instruction per cycle.
- Stall: a stalled buffer holds. disp_* data outputs stay stable while a pulse is pending.
- rob_count: +1 on dispatch, −1 on commit_valid, unchanged when both occur.
  - commit_valid with rob_count==0 is ignored. This is a bench assertion.
- FSM:
  - RUN→HALTED on the cycle HALT dispatches. inst_ready is held 0 and halted=1.
  - HALTED→RUN only on flush.
- Flush:
  - Highest priority over dispatch and accept in the same cycle.
  - Clears the buffer and sets rob_count=0. tail is not changed.
  - Returns state to RUN and suppresses all pulses that cycle.
  - commit_valid in a flush cycle is ignored.
- Reset mid-stall: the buffer and its contents are discarded immediately.

Optional Feature:
DISPATCH_PERF_CNT_EN:
- Defined: adds output stall_cycles (32-bit). It increments each cycle the buffer is valid with a non-DROP class and does not dispatch. It saturates at 0xFFFFFFFF and is cleared by reset only.
- Undefined: no port and no counter logic.

Decomposition:
- Shared package ooo_pkg holds:
  - all opcode localparams (0x00–0x31);
  - the class enum {CLS_ALU, CLS_LSQ, CLS_BR, CLS_DROP};
  - the FSM state enum {ST_RUN, ST_HALTED}.
- One sub-module, dispatch_classify: combinational opcode → class plus disp_wr_rd, disp_reg_dest, disp_mem_wen, is_halt. It is reusable by the decode stage and the simulator's checker.

Test Plan:
1. Reset, then ADD (0x01), LW (0x11), BEQ (0x14) on consecutive cycles with no full → alu_disp, lsq_disp, br_disp on cycles 1, 2, 3 with tags 0, 1, 2; disp_wr_rd=1 only for ADD; rob_count=3.
2. SW with lsq_full=1 for 4 cycles → inst_ready=0 for those 4 cycles, then lsq_disp=1 with disp_mem_wen=1 when lsq_full drops; stall_cycles=4 if DISPATCH_PERF_CNT_EN.
3. Dispatch 16 ALU ops with no commit → rob_count=16 and the 17th holds. One commit_valid → 17th dispatches with tag 0 (wrap).
4. NOP (0x00), TX (0x30), 0x3F streamed → no dispatch pulses, tail unchanged, inst_ready stays 1.
5. HALT dispatched → br_disp once, halted=1, inst_ready=0 while inst_valid is held. flush → halted=0, rob_count=0, inst_ready=1 the next cycle.
6. flush asserted in the same cycle as a dispatchable buffer plus commit_valid → no pulse, buffer empty, rob_count=0. Assert rst_n low mid-stall → all outputs return to reset values asynchronously.
